// File: rtl/axi_xbar_pkg.sv
// Shared types and defaults for the AXI crossbar address-channel arbiters.
package axi_xbar_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int STARVE_LIMIT_DEF = 64;

endpackage

// File: rtl/axi_xbar_rr_pick.sv
// Cyclic first-set search starting at a pointer; returns winner index and found flag.
module axi_xbar_rr_pick #(
  parameter int NUM_REQ  = 5,
  parameter int IDX_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  i_reqs,
  input  logic [IDX_BITS-1:0] i_ptr,
  output logic [IDX_BITS-1:0] o_idx,
  output logic                o_found
);

  localparam logic [IDX_BITS:0] N_EXT = (IDX_BITS + 1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_BITS-1:0]  w_off;
  logic [IDX_BITS:0]    w_sum;

  // Rotating a doubled copy puts the request at i_ptr in bit 0.
  assign w_dbl = {i_reqs, i_reqs};
  assign w_rot = NUM_REQ'(w_dbl >> i_ptr);

  always_comb begin
    w_off   = '0;
    o_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off   = IDX_BITS'(k);
        o_found = 1'b1;
      end
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= N_EXT) ? IDX_BITS'(w_sum - N_EXT) : w_sum[IDX_BITS-1:0];

endmodule

// File: rtl/axi_xbar_wrr_arb.sv
// Weighted round-robin AW/AR arbiter with handshake-locked grant, optional
// strict-priority top requester and a starvation guard on that requester.
module axi_xbar_wrr_arb
  import axi_xbar_pkg::*;
#(
  parameter int NUM_REQ      = 5,
  parameter bit PRIO_EN      = 1'b1,
  parameter int WEIGHT_BITS  = 4,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int IDX_BITS     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             reqs,
  input  logic [NUM_REQ*WEIGHT_BITS-1:0] weights,
  input  logic                           accept,
  output logic                           grant_valid,
  output logic [NUM_REQ-1:0]             grant_b,
  output logic [IDX_BITS-1:0]            grant_i,
  output logic                           starve_active
);

  localparam int                     CNT_BITS = $clog2(STARVE_LIMIT + 1);
  localparam logic [IDX_BITS-1:0]    PRIO_IDX = IDX_BITS'(NUM_REQ - 1);
  localparam logic [IDX_BITS-1:0]    LAST_RR  = IDX_BITS'(PRIO_EN ? NUM_REQ - 2 : NUM_REQ - 1);
  localparam logic [CNT_BITS-1:0]    CNT_LAST = CNT_BITS'(STARVE_LIMIT - 1);
  localparam logic [WEIGHT_BITS-1:0] ONE_W    = WEIGHT_BITS'(1);

  arb_state_t              r_state, w_state_next;
  logic [IDX_BITS-1:0]     r_rr_ptr, r_lock_idx;
  logic [WEIGHT_BITS-1:0]  r_credit;
  logic [CNT_BITS-1:0]     r_starve_cnt;
  logic                    r_starve_active;

  logic [WEIGHT_BITS-1:0]  w_eff_weight [NUM_REQ];
  logic [NUM_REQ-1:0]      w_prio_bit, w_rr_reqs;
  logic [IDX_BITS-1:0]     w_pick_idx, w_win_idx, w_grant_idx, w_next_ptr;
  logic                    w_pick_found, w_prio_win, w_win_found;
  logic                    w_grant_valid, w_acc, w_is_prio, w_any_rr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_weight
      assign w_eff_weight[gi] = (weights[gi*WEIGHT_BITS +: WEIGHT_BITS] == '0)
                              ? ONE_W : weights[gi*WEIGHT_BITS +: WEIGHT_BITS];
    end
  endgenerate

  // The priority requester joins the rotation only while the guard is active.
  assign w_prio_bit = PRIO_EN ? (NUM_REQ'(1) << PRIO_IDX) : '0;
  assign w_rr_reqs  = r_starve_active ? reqs : (reqs & ~w_prio_bit);
  assign w_any_rr   = |(reqs & ~w_prio_bit);

  axi_xbar_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .IDX_BITS (IDX_BITS)
  ) u_pick (
    .i_reqs  (w_rr_reqs),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_prio_win    = PRIO_EN && reqs[PRIO_IDX] && !r_starve_active;
  assign w_win_idx     = w_prio_win ? PRIO_IDX : w_pick_idx;
  assign w_win_found   = w_prio_win || w_pick_found;
  assign w_grant_idx   = (r_state == LOCKED) ? r_lock_idx : w_win_idx;
  assign w_grant_valid = !rst && ((r_state == LOCKED) || w_win_found);
  assign w_acc         = accept && w_grant_valid;
  assign w_is_prio     = PRIO_EN && (w_grant_idx == PRIO_IDX) && !r_starve_active;
  assign w_next_ptr    = (w_grant_idx >= LAST_RR) ? '0 : w_grant_idx + IDX_BITS'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_win_found && !accept) w_state_next = LOCKED;
      LOCKED:  if (accept) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_valid = w_grant_valid;
    grant_i     = w_grant_valid ? w_grant_idx : '0;
    grant_b     = '0;
    if (w_grant_valid) grant_b[w_grant_idx] = 1'b1;
    starve_active = r_starve_active && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr        <= '0;
      r_credit        <= w_eff_weight[0];
      r_starve_cnt    <= '0;
      r_starve_active <= 1'b0;
      r_lock_idx      <= '0;
    end else begin
      if ((r_state == IDLE) && w_win_found && !accept) r_lock_idx <= w_win_idx;
      if (w_acc) begin
        if (w_is_prio) begin
          if (w_any_rr) begin
            if (r_starve_cnt == CNT_LAST) begin
              r_starve_active <= 1'b1;
              r_starve_cnt    <= '0;
            end else begin
              r_starve_cnt <= r_starve_cnt + CNT_BITS'(1);
            end
          end else begin
            r_starve_cnt <= '0;
          end
        end else begin
          r_starve_active <= 1'b0;
          // A winner other than rr_ptr starts its own burst; the pointer never hoards.
          if ((w_grant_idx == r_rr_ptr) && (r_credit > ONE_W)) begin
            r_credit <= r_credit - ONE_W;
          end else if ((w_grant_idx != r_rr_ptr) && (w_eff_weight[w_grant_idx] > ONE_W)) begin
            r_rr_ptr <= w_grant_idx;
            r_credit <= w_eff_weight[w_grant_idx] - ONE_W;
          end else begin
            r_rr_ptr <= w_next_ptr;
            r_credit <= w_eff_weight[w_next_ptr];
          end
        end
      end
    end
  end

  a_accept_needs_grant: assert property (@(posedge clk) disable iff (rst) accept |-> w_grant_valid);

endmodule

// File: tb/tb_axi_xbar_wrr_arb.sv
// Bench for axi_xbar_wrr_arb: fixed vector table, hand sequences and a random run
// against a rule-level model; one instance with a priority port, one without.
module tb_axi_xbar_wrr_arb;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] reqs_s [2];
  logic [4*N-1:0] wts_s [2];
  logic         acc_s [2];
  logic         gv_o [2];
  logic [N-1:0] gb_o [2];
  logic [2:0]   gi_o [2];
  logic         sa_o [2];

  always #5 clk = ~clk;

  axi_xbar_wrr_arb #(
    .NUM_REQ(5), .PRIO_EN(1'b1), .WEIGHT_BITS(4), .STARVE_LIMIT(4)
  ) dut_prio (
    .clk(clk), .rst(rst), .reqs(reqs_s[0]), .weights(wts_s[0]), .accept(acc_s[0]),
    .grant_valid(gv_o[0]), .grant_b(gb_o[0]), .grant_i(gi_o[0]), .starve_active(sa_o[0])
  );

  axi_xbar_wrr_arb #(
    .NUM_REQ(5), .PRIO_EN(1'b0), .WEIGHT_BITS(4), .STARVE_LIMIT(64)
  ) dut_rr (
    .clk(clk), .rst(rst), .reqs(reqs_s[1]), .weights(wts_s[1]), .accept(acc_s[1]),
    .grant_valid(gv_o[1]), .grant_b(gb_o[1]), .grant_i(gi_o[1]), .starve_active(sa_o[1])
  );

  // ---------------- reference model ----------------
  bit prio_en [2] = '{1'b1, 1'b0};
  int limit   [2] = '{4, 64};
  bit m_locked [2];
  int m_lock [2];
  int m_ptr [2];
  int m_credit [2];
  int m_cnt [2];
  bit m_sa [2];

  function automatic int eff_w(int d, int i);
    int v;
    v = int'(wts_s[d][4*i +: 4]);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic bit is_member(int d, int i);
    return !(prio_en[d] && i == N - 1 && !m_sa[d]);
  endfunction

  function automatic int m_winner(int d);
    if (m_locked[d]) return m_lock[d];
    if (prio_en[d] && reqs_s[d][N-1] && !m_sa[d]) return N - 1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr[d] + k) % N;
      if (reqs_s[d][i] && is_member(d, i)) return i;
    end
    return -1;
  endfunction

  function automatic void model_step(int d);
    int w;
    int nxt;
    if (rst) begin
      m_locked[d] = 0; m_lock[d] = 0; m_ptr[d] = 0;
      m_credit[d] = eff_w(d, 0); m_cnt[d] = 0; m_sa[d] = 0;
      return;
    end
    w = m_winner(d);
    if (w < 0) return;
    if (!acc_s[d]) begin
      if (!m_locked[d]) begin m_locked[d] = 1; m_lock[d] = w; end
      return;
    end
    m_locked[d] = 0;
    if (prio_en[d] && w == N - 1 && !m_sa[d]) begin
      if (reqs_s[d][N-2:0] != '0) begin
        m_cnt[d]++;
        if (m_cnt[d] == limit[d]) begin m_sa[d] = 1; m_cnt[d] = 0; end
      end else begin
        m_cnt[d] = 0;
      end
    end else begin
      m_sa[d] = 0;
      if (w == m_ptr[d] && m_credit[d] > 1) begin
        m_credit[d]--;
      end else if (w != m_ptr[d] && eff_w(d, w) > 1) begin
        m_ptr[d] = w;
        m_credit[d] = eff_w(d, w) - 1;
      end else begin
        nxt = (w == N - 1) ? 0 : (w + 1) % (prio_en[d] ? N - 1 : N);
        m_ptr[d] = nxt;
        m_credit[d] = eff_w(d, nxt);
      end
    end
  endfunction

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic step(input int d, input bit rs, input logic [19:0] w, input logic [4:0] r,
                      input bit acc, input bit fixed, input bit egv, input int egi,
                      input bit esa, input string nm);
    bit xgv, xsa;
    int xgi, win;
    logic [4:0] xgb;
    rst = rs;
    for (int k = 0; k < 2; k++) begin
      reqs_s[k] = '0;
      acc_s[k]  = 1'b0;
    end
    reqs_s[d] = r;
    wts_s[d]  = w;
    acc_s[d]  = acc;
    #1;
    if (fixed) begin
      xgv = egv; xgi = egi; xsa = esa;
    end else if (rs) begin
      xgv = 0; xgi = 0; xsa = 0;
    end else begin
      win = m_winner(d);
      xgv = (win >= 0);
      xgi = xgv ? win : 0;
      xsa = m_sa[d];
    end
    xgb = xgv ? (5'b00001 << xgi) : 5'b00000;
    n_cmp++;
    if (gv_o[d] !== xgv || gi_o[d] !== 3'(xgi) || gb_o[d] !== xgb || sa_o[d] !== xsa) begin
      n_err++;
      $display("FAIL %s dut=%0d rst=%b reqs=%b acc=%b: got gv=%b gi=%0d gb=%b sa=%b, need gv=%b gi=%0d gb=%b sa=%b",
               nm, d, rs, r, acc, gv_o[d], gi_o[d], gb_o[d], sa_o[d], xgv, xgi, xgb, xsa);
    end else begin
      $display("ok   %s dut=%0d rst=%b reqs=%b acc=%b gv=%b gi=%0d sa=%b",
               nm, d, rs, r, acc, gv_o[d], gi_o[d], sa_o[d]);
    end
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  typedef struct {
    int         d;
    bit         rs;
    logic [19:0] w;
    logic [4:0] r;
    bit         acc;
    bit         gv;
    int         gi;
    bit         sa;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int d, bit rs, logic [19:0] w, logic [4:0] r, bit acc,
                              bit gv, int gi, bit sa, string nm);
    vec_t v;
    v.d = d; v.rs = rs; v.w = w; v.r = r; v.acc = acc;
    v.gv = gv; v.gi = gi; v.sa = sa; v.nm = nm;
    tbl.push_back(v);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] w1, w2, wr;
    logic [4:0]  r;
    bit          rs, acc;
    int          win;
    w1 = 20'h11111;
    w2 = 20'h11113;

    // Plain rotation with unit weights, zero-latency grant.
    add(0, 1, w1, 5'b00000, 0, 0, 0, 0, "t1_reset");
    add(0, 0, w1, 5'b00110, 1, 1, 1, 0, "t1_rr");
    add(0, 0, w1, 5'b00110, 1, 1, 2, 0, "t1_rr");
    add(0, 0, w1, 5'b00110, 1, 1, 1, 0, "t1_rr");
    add(0, 0, w1, 5'b00110, 1, 1, 2, 0, "t1_rr");
    // Weight 3 on requester 0.
    add(0, 1, w2, 5'b00000, 0, 0, 0, 0, "t2_reset");
    add(0, 0, w2, 5'b00011, 1, 1, 0, 0, "t2_wrr");
    add(0, 0, w2, 5'b00011, 1, 1, 0, 0, "t2_wrr");
    add(0, 0, w2, 5'b00011, 1, 1, 0, 0, "t2_wrr");
    add(0, 0, w2, 5'b00011, 1, 1, 1, 0, "t2_wrr");
    add(0, 0, w2, 5'b00011, 1, 1, 0, 0, "t2_wrr");
    add(0, 0, w2, 5'b00011, 1, 1, 0, 0, "t2_wrr");
    add(0, 0, w2, 5'b00011, 1, 1, 0, 0, "t2_wrr");
    add(0, 0, w2, 5'b00011, 1, 1, 1, 0, "t2_wrr");
    // Starvation guard with limit 4.
    add(0, 1, w1, 5'b00000, 0, 0, 0, 0, "t4_reset");
    add(0, 0, w1, 5'b10100, 1, 1, 4, 0, "t4_prio");
    add(0, 0, w1, 5'b10100, 1, 1, 4, 0, "t4_prio");
    add(0, 0, w1, 5'b10100, 1, 1, 4, 0, "t4_prio");
    add(0, 0, w1, 5'b10100, 1, 1, 4, 0, "t4_prio");
    add(0, 0, w1, 5'b10100, 1, 1, 2, 1, "t4_starve");
    add(0, 0, w1, 5'b10100, 1, 1, 4, 0, "t4_resume");
    // No priority port: full rotation including index 4.
    add(1, 1, w1, 5'b00000, 0, 0, 0, 0, "t5_reset");
    add(1, 0, w1, 5'b11111, 1, 1, 0, 0, "t5_rr");
    add(1, 0, w1, 5'b11111, 1, 1, 1, 0, "t5_rr");
    add(1, 0, w1, 5'b11111, 1, 1, 2, 0, "t5_rr");
    add(1, 0, w1, 5'b11111, 1, 1, 3, 0, "t5_rr");
    add(1, 0, w1, 5'b11111, 1, 1, 4, 0, "t5_rr");
    add(1, 0, w1, 5'b11111, 1, 1, 0, 0, "t5_rr");

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      reqs_s[k] = '0; wts_s[k] = w1; acc_s[k] = 1'b0;
    end
    @(negedge clk);

    foreach (tbl[i])
      step(tbl[i].d, tbl[i].rs, tbl[i].w, tbl[i].r, tbl[i].acc, 1'b1,
           tbl[i].gv, tbl[i].gi, tbl[i].sa, tbl[i].nm);

    // Grant stays locked without accept; priority arriving meanwhile waits.
    step(0, 1, w1, 5'b00000, 0, 1, 0, 0, 0, "t3_reset");
    step(0, 0, w1, 5'b00001, 0, 1, 1, 0, 0, "t3_lock");
    step(0, 0, w1, 5'b00001, 0, 1, 1, 0, 0, "t3_lock");
    step(0, 0, w1, 5'b10001, 0, 1, 1, 0, 0, "t3_hold");
    step(0, 0, w1, 5'b10001, 0, 1, 1, 0, 0, "t3_hold");
    step(0, 0, w1, 5'b10001, 0, 1, 1, 0, 0, "t3_hold");
    step(0, 0, w1, 5'b10001, 1, 1, 1, 0, 0, "t3_accept");
    step(0, 0, w1, 5'b10001, 1, 1, 1, 4, 0, "t3_prio_next");

    // Reset while locked drops the grant immediately and restarts at rr_ptr 0.
    step(1, 1, w1, 5'b00000, 0, 1, 0, 0, 0, "t6_reset");
    step(1, 0, w1, 5'b01000, 0, 1, 1, 3, 0, "t6_lock");
    step(1, 0, w1, 5'b10000, 0, 1, 1, 3, 0, "t6_locked");
    step(1, 1, w1, 5'b10000, 0, 1, 0, 0, 0, "t6_rst_drop");
    step(1, 0, w1, 5'b00000, 0, 1, 0, 0, 0, "t6_idle");
    step(1, 0, w1, 5'b11000, 1, 1, 1, 3, 0, "t6_restart");

    // Random traffic against the model; accept only when a grant is predicted.
    for (int d = 0; d < 2; d++) begin
      wr = 20'($urandom);
      step(d, 1, wr, 5'b00000, 0, 0, 0, 0, 0, "rand_reset");
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 31) == 0) wr = 20'($urandom);
        r = ($urandom_range(0, 3) == 0) ? 5'b00000 : 5'($urandom);
        if (d == 0 && $urandom_range(0, 1) == 1) r = r | 5'b10000;
        rs = ($urandom_range(0, 99) == 0);
        reqs_s[d] = r;
        wts_s[d]  = wr;
        rst       = rs;
        win = m_winner(d);
        acc = (!rs && win >= 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
        step(d, rs, wr, r, acc, 0, 0, 0, 0, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
